// File: rtl/score_ctl_if.sv
// Pong scoring bus: ball position and restart in, scores and serve control out.
interface score_ctl_if;
  logic [10:0] xpos;
  logic        restart;
  logic [6:0]  points_first_player;
  logic [6:0]  points_second_player;
  logic        serve;
  logic        serve_dir;
  logic        game_over;
  logic        winner;

  modport master (
    output xpos, restart,
    input  points_first_player, points_second_player, serve, serve_dir, game_over, winner
  );

  modport slave (
    input  xpos, restart,
    output points_first_player, points_second_player, serve, serve_dir, game_over, winner
  );
endinterface

// File: rtl/score_ctl.sv
// Pong scoring and serve sequencer: counts goals at the field edges, paces serves, ends the game.
// Define SCORE_WIN_BY_TWO_EN to require a two-point lead for the win (deuce play).
module score_ctl #(
  parameter int unsigned LEFT_EDGE   = 0,
  parameter int unsigned RIGHT_EDGE  = 1024,
  parameter int unsigned WIN_POINTS  = 11,
  parameter int unsigned SERVE_DELAY = 65_000_000
) (
  input  logic        clk,
  input  logic        rst,
  score_ctl_if.slave  bus
);

  localparam int unsigned     CntW      = $clog2(SERVE_DELAY);
  localparam logic [CntW-1:0] CntMax    = CntW'(SERVE_DELAY - 1);
  localparam logic [10:0]     LeftEdge  = 11'(LEFT_EDGE);
  localparam logic [10:0]     RightEdge = 11'(RIGHT_EDGE);
  localparam logic [6:0]      WinPts    = 7'(WIN_POINTS);
  localparam logic [6:0]      MaxPts    = 7'd99;

  typedef enum logic [1:0] {StServeWait, StPlay, StGameOver} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [6:0]      p1_q, p1_d, p2_q, p2_d;
  logic            serve_q, serve_d, dir_q, dir_d;
  logic            over_q, over_d, winner_q, winner_d;
  logic            armed_q, armed_d;

  logic       cnt_done, interior, goal_left, goal_right;
  logic [6:0] p1_new, p2_new;
  logic       p1_wins, p2_wins;

  assign cnt_done   = (state_q == StServeWait) && (cnt_q == CntMax);
  assign interior   = (bus.xpos > LeftEdge) && (bus.xpos < RightEdge);
  assign goal_left  = (state_q == StPlay) && armed_q && (bus.xpos <= LeftEdge);
  assign goal_right = (state_q == StPlay) && armed_q && !goal_left && (bus.xpos >= RightEdge);

  assign p1_new = (p1_q == MaxPts) ? MaxPts : p1_q + 7'd1;
  assign p2_new = (p2_q == MaxPts) ? MaxPts : p2_q + 7'd1;

`ifdef SCORE_WIN_BY_TWO_EN
  // Reaching 99 always wins, otherwise saturation could stall a deuce forever.
  assign p1_wins = (p1_new == MaxPts) ||
                   ((p1_new >= WinPts) && ({1'b0, p1_new} >= {1'b0, p2_q} + 8'd2));
  assign p2_wins = (p2_new == MaxPts) ||
                   ((p2_new >= WinPts) && ({1'b0, p2_new} >= {1'b0, p1_q} + 8'd2));
`else
  assign p1_wins = (p1_new == WinPts);
  assign p2_wins = (p2_new == WinPts);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StServeWait;
      cnt_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      serve_q  <= 1'b0;
      dir_q    <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      serve_q  <= serve_d;
      dir_q    <= dir_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.restart) begin
      state_d = StServeWait;
    end else begin
      unique case (state_q)
        StServeWait: if (cnt_done) state_d = StPlay;
        StPlay: begin
          if (goal_left)       state_d = p2_wins ? StGameOver : StServeWait;
          else if (goal_right) state_d = p1_wins ? StGameOver : StServeWait;
        end
        StGameOver: state_d = StGameOver;
        default:    state_d = StServeWait;
      endcase
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    serve_d  = 1'b0;
    dir_d    = dir_q;
    over_d   = over_q;
    winner_d = winner_q;
    armed_d  = armed_q;
    if (bus.restart) begin
      cnt_d    = '0;
      p1_d     = '0;
      p2_d     = '0;
      dir_d    = 1'b0;
      over_d   = 1'b0;
      winner_d = 1'b0;
      armed_d  = 1'b0;
    end else begin
      unique case (state_q)
        StServeWait: begin
          cnt_d   = cnt_done ? '0 : cnt_q + 1'b1;
          serve_d = cnt_done;
        end
        StPlay: begin
          if (interior) armed_d = 1'b1;
          if (goal_left) begin
            p2_d    = p2_new;
            dir_d   = 1'b0;
            armed_d = 1'b0;
            if (p2_wins) begin
              over_d   = 1'b1;
              winner_d = 1'b1;
            end
          end else if (goal_right) begin
            p1_d    = p1_new;
            dir_d   = 1'b1;
            armed_d = 1'b0;
            if (p1_wins) begin
              over_d   = 1'b1;
              winner_d = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.points_first_player  = p1_q;
  assign bus.points_second_player = p2_q;
  assign bus.serve                = serve_q;
  assign bus.serve_dir            = dir_q;
  assign bus.game_over            = over_q;
  assign bus.winner               = winner_q;

endmodule

// File: tb/tb_score_ctl.sv
// Directed bench for score_ctl with SERVE_DELAY = 4 and WIN_POINTS = 3.
module tb_score_ctl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  score_ctl_if sif ();

  score_ctl #(
    .LEFT_EDGE  (0),
    .RIGHT_EDGE (1024),
    .WIN_POINTS (3),
    .SERVE_DELAY(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] xpos;
    logic        restart;
    logic [6:0]  p1;
    logic [6:0]  p2;
    logic        serve;
    logic        dir;
    logic        over;
    logic        win;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input int x, input bit rs, input int p1, input int p2,
                             input bit sv, input bit dir, input bit ov, input bit wn);
    vec_t r;
    r.xpos = 11'(x);  r.restart = rs;   r.p1 = 7'(p1); r.p2 = 7'(p2);
    r.serve = sv;     r.dir = dir;      r.over = ov;   r.win = wn;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, sif.points_first_player, sif.points_second_player, sif.serve,
            sif.serve_dir, sif.game_over, sif.winner};
  endfunction

  task automatic do_restart();
    sif.restart = 1'b1;
    sif.xpos    = 11'd512;
    tick();
    sif.restart = 1'b0;
    repeat (3) tick();
    tick();
    check("restart serve", {31'd0, sif.serve}, 32'd1);
  endtask

  task automatic play_point(input bit to_second);
    sif.xpos = 11'd512;
    tick();
    sif.xpos = to_second ? 11'd0 : 11'd1024;
    tick();
    sif.xpos = 11'd512;
    repeat (4) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    sif.xpos = 11'd512;
    sif.restart = 1'b0;

    // xpos, restart | p1, p2, serve, dir, over, winner (after the edge)
    repeat (3) vecs.push_back(v(512, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(512, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(512, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));
    repeat (3) vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0));
    repeat (5) vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(512, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(1024, 0, 1, 1, 0, 1, 0, 0));
    repeat (3) vecs.push_back(v(1030, 0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(1030, 0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(v(1030, 0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(512, 0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(1024, 0, 2, 1, 0, 1, 0, 0));
    repeat (3) vecs.push_back(v(512, 0, 2, 1, 0, 1, 0, 0));
    vecs.push_back(v(512, 0, 2, 1, 1, 1, 0, 0));
    vecs.push_back(v(512, 0, 2, 1, 0, 1, 0, 0));
    vecs.push_back(v(1024, 0, 3, 1, 0, 1, 1, 0));
    vecs.push_back(v(512, 0, 3, 1, 0, 1, 1, 0));
    vecs.push_back(v(0, 0, 3, 1, 0, 1, 1, 0));
    vecs.push_back(v(1024, 0, 3, 1, 0, 1, 1, 0));
    repeat (2) vecs.push_back(v(512, 0, 3, 1, 0, 1, 1, 0));
    vecs.push_back(v(512, 1, 0, 0, 0, 0, 0, 0));
    repeat (3) vecs.push_back(v(512, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(512, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(512, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 0));
    repeat (3) vecs.push_back(v(512, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(512, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(512, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    check("reset state", outs(), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      sif.xpos    = vecs[i].xpos;
      sif.restart = vecs[i].restart;
      tick();
      check($sformatf("row %0d", i + 1), outs(),
            {14'd0, vecs[i].p1, vecs[i].p2, vecs[i].serve, vecs[i].dir,
             vecs[i].over, vecs[i].win});
    end
    sif.restart = 1'b0;

    // Second player wins on the left edge, 1..3.
    do_restart();
    play_point(1'b1);
    play_point(1'b0);
    play_point(1'b1);
    play_point(1'b1);
    check("p2 win p1", 32'(sif.points_first_player), 32'd1);
    check("p2 win p2", 32'(sif.points_second_player), 32'd3);
    check("p2 win over", {31'd0, sif.game_over}, 32'd1);
    check("p2 win winner", {31'd0, sif.winner}, 32'd1);
    check("p2 win no serve", {31'd0, sif.serve}, 32'd0);

`ifdef SCORE_WIN_BY_TWO_EN
    do_restart();
    for (int k = 0; k < 3; k++) begin
      play_point(1'b0);
      play_point(1'b1);
    end
    check("deuce 3/3", outs(), {14'd0, 7'd3, 7'd3, 1'b0, 1'b0, 1'b0, 1'b0});
    play_point(1'b0);
    check("adv 4/3", outs(), {14'd0, 7'd4, 7'd3, 1'b0, 1'b1, 1'b0, 1'b0});
    play_point(1'b0);
    check("win 5/3", outs(), {14'd0, 7'd5, 7'd3, 1'b0, 1'b1, 1'b1, 1'b0});
`endif

    // Asynchronous reset in the middle of the serve pause.
    do_restart();
    sif.xpos = 11'd512;
    tick();
    sif.xpos = 11'd1024;
    tick();
    check("pre-reset score", outs(), {14'd0, 7'd1, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    sif.xpos = 11'd512;
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("async reset", outs(), 32'd0);
    #1;
    rst = 1'b1;
    repeat (3) tick();
    check("post-reset wait", {31'd0, sif.serve}, 32'd0);
    tick();
    check("post-reset serve", {31'd0, sif.serve}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
